// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//   Multi-cycle controller that walks one ALU operation through the shared
//   combinational ALU: accept -> LOADY -> EXEC (stretched for MUL/DIV) ->
//   CAPT -> WBLO -> (WBHI for MUL/DIV) -> IDLE.
//
//   Optional feature macro: DIVZERO_TRAP_EN
//     defined   : DIV with B==0 is rejected in LOADY with an err pulse.
//     undefined : DIV by zero is sequenced like any other DIV.
//
// Ports
//   clk                   rising-edge clock
//   clear                 asynchronous reset, active low
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_opcode/ra/rb      request opcode and operands
//   alu_a/alu_b/alu_op    drive the combinational ALU
//   alu_result            64-bit ALU output, captured into Z in CAPT
//   lo_we/hi_we           1-cycle writeback strobes for result_lo/result_hi
//   result_lo/result_hi   Z[31:0] / Z[63:32]
//   done                  1-cycle pulse on final writeback cycle
//   err                   1-cycle pulse on rejected request
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_ra,
    input  logic [31:0] req_rb,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_result,
    output logic        lo_we,
    output logic        hi_we,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        done,
    output logic        err
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_SHRA = 5'b10010;

    localparam logic [3:0] WAIT_LD = 4'(MULDIV_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADY,
        S_EXEC,
        S_CAPT,
        S_WBLO,
        S_WBHI
    } state_t;

    state_t      state, nxt;
    logic [31:0] y_reg;
    logic [31:0] b_reg;
    logic [31:0] ra_hold;     // Ra as seen at accept; moved into Y during LOADY
    logic [63:0] z_reg;
    logic [4:0]  op_reg;
    logic [3:0]  cnt;

    logic accept;
    logic op_legal;
    logic op_muldiv;
    logic div_trap;

    function automatic logic legal_fn(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
            OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_SHRA: legal_fn = 1'b1;
            default:                                 legal_fn = 1'b0;
        endcase
    endfunction

    assign accept    = req_valid & req_ready;
    assign op_legal  = legal_fn(op_reg);
    assign op_muldiv = (op_reg == OP_MUL) || (op_reg == OP_DIV);

`ifdef DIVZERO_TRAP_EN
    assign div_trap  = (op_reg == OP_DIV) && (b_reg == 32'd0);
`else
    assign div_trap  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next state and strobes
    always_comb begin
        nxt       = state;
        req_ready = 1'b0;
        lo_we     = 1'b0;
        hi_we     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) nxt = S_LOADY;
            end
            S_LOADY: begin
                if (!op_legal || div_trap) begin
                    err = 1'b1;
                    nxt = S_IDLE;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // Non MUL/DIV leave after one cycle; MUL/DIV run the counter down.
                if (!op_muldiv || cnt == 4'd0) nxt = S_CAPT;
            end
            S_CAPT: nxt = S_WBLO;
            S_WBLO: begin
                lo_we = 1'b1;
                if (op_muldiv) begin
                    nxt = S_WBHI;
                end else begin
                    done = 1'b1;
                    nxt  = S_IDLE;
                end
            end
            S_WBHI: begin
                hi_we = 1'b1;
                done  = 1'b1;
                nxt   = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            y_reg   <= '0;
            b_reg   <= '0;
            ra_hold <= '0;
            z_reg   <= '0;
            op_reg  <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                op_reg  <= req_opcode;
                ra_hold <= req_ra;
                // NEG/NOT are unary: keep B at zero so the ALU sees a clean operand.
                b_reg   <= (req_opcode == OP_NEG || req_opcode == OP_NOT) ? 32'd0 : req_rb;
            end
            if (state == S_LOADY) y_reg <= ra_hold;
            if (state == S_LOADY && nxt == S_EXEC)  cnt <= WAIT_LD;
            else if (state == S_EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == S_CAPT) z_reg <= alu_result;
        end
    end

    assign alu_a     = y_reg;
    assign alu_b     = b_reg;
    assign alu_op    = op_reg;
    assign result_lo = z_reg[31:0];
    assign result_hi = z_reg[63:32];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Directed and randomized bench for alu_op_sequencer. A behavioural ALU
//   drives alu_result; the expected strobe schedule, latencies and Z contents
//   are derived per request from the opcode rules.
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int W = 4;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_SHRA = 5'b10010;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_opcode = '0;
    logic [31:0] req_ra = '0;
    logic [31:0] req_rb = '0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [63:0] alu_result;
    logic        lo_we, hi_we, done, err;
    logic [31:0] result_lo, result_hi;

    int nvec = 0;
    int nmis = 0;
    logic [63:0] zm = '0;   // expected Z contents

    always #5 clk = ~clk;

    alu_op_sequencer #(.MULDIV_WAIT(W)) dut (
        .clk(clk), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_ra(req_ra), .req_rb(req_rb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .lo_we(lo_we), .hi_we(hi_we),
        .result_lo(result_lo), .result_hi(result_hi),
        .done(done), .err(err)
    );

    // Behavioural ALU; divide by zero returns a recognisable pattern.
    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]         s;
        logic signed [63:0] sa, sb;
        logic signed [31:0] q, r;
        s  = b[4:0];
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            OP_ADD:  alu_fn = {32'd0, a + b};
            OP_SUB:  alu_fn = {32'd0, a - b};
            OP_SHR:  alu_fn = {32'd0, a >> s};
            OP_SHL:  alu_fn = {32'd0, a << s};
            OP_ROR:  alu_fn = {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
            OP_ROL:  alu_fn = {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
            OP_AND:  alu_fn = {32'd0, a & b};
            OP_OR:   alu_fn = {32'd0, a | b};
            OP_MUL:  alu_fn = sa * sb;
            OP_DIV: begin
                if (b == 32'd0) begin
                    alu_fn = 64'hDEAD_BEEF_0BAD_F00D;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    alu_fn = {r, q};
                end
            end
            OP_NEG:  alu_fn = {32'd0, 32'd0 - a};
            OP_NOT:  alu_fn = {32'd0, ~a};
            OP_SHRA: alu_fn = {32'd0, 32'($signed(a) >>> s)};
            default: alu_fn = 64'd0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

    function automatic bit is_legal(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND,
                          OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_SHRA};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request right after a negedge in IDLE, follows it to the
    // next IDLE cycle, and returns just after that IDLE cycle's negedge.
    // chain keeps req_valid high with the next request's fields.
    task automatic do_op(input logic [4:0] op, input logic [31:0] ra, input logic [31:0] rb,
                         input bit chain, input logic [4:0] nop, input logic [31:0] nra,
                         input logic [31:0] nrb);
        logic [31:0] bx;
        logic [63:0] r;
        bit trap, bad, md;
        int exec_len, done_c, lo_c, last;
        bx   = (op == OP_NEG || op == OP_NOT) ? 32'd0 : rb;
        trap = 1'b0;
`ifdef DIVZERO_TRAP_EN
        trap = (op == OP_DIV) && (rb == 32'd0);
`endif
        bad      = !is_legal(op) || trap;
        md       = (op == OP_MUL) || (op == OP_DIV);
        exec_len = md ? 1 + W : 1;
        done_c   = md ? 5 + W : 4;
        lo_c     = md ? done_c - 1 : done_c;
        last     = bad ? 1 : done_c;
        r        = alu_fn(op, ra, bx);

        req_valid = 1'b1; req_opcode = op; req_ra = ra; req_rb = rb;
        chk("ready_at_req", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        if (chain) begin
            req_opcode = nop; req_ra = nra; req_rb = nrb;
        end else begin
            req_valid = 1'b0;
            req_opcode = 5'($urandom); req_ra = $urandom; req_rb = $urandom;
        end
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            chk("err",   {63'd0, err},   {63'd0, bad && c == 1});
            chk("lo_we", {63'd0, lo_we}, {63'd0, !bad && c == lo_c});
            chk("hi_we", {63'd0, hi_we}, {63'd0, !bad && md && c == done_c});
            chk("done",  {63'd0, done},  {63'd0, !bad && c == done_c});
            chk("busy_ready", {63'd0, req_ready}, 64'd0);
            if (!bad && c >= 2 && c <= 2 + exec_len) begin
                chk("alu_a",  {32'd0, alu_a},  {32'd0, ra});
                chk("alu_b",  {32'd0, alu_b},  {32'd0, bx});
                chk("alu_op", {59'd0, alu_op}, {59'd0, op});
            end
            if (!bad && c >= lo_c) zm = r;
            if (bad || c >= lo_c) chk("z", {result_hi, result_lo}, zm);
        end
        @(negedge clk);
        chk("idle_ready",   {63'd0, req_ready}, 64'd1);
        chk("idle_strobes", {60'd0, lo_we, hi_we, done, err}, 64'd0);
        chk("idle_z",       {result_hi, result_lo}, zm);
    endtask

    logic [4:0]  legal_ops [13] = '{OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND,
                                     OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_SHRA};
    logic [4:0]  rop [41];
    logic [31:0] rra [41];
    logic [31:0] rrb [41];
    bit          rch [41];

    initial begin
        // Reset state
        #12;
        @(negedge clk);
        chk("rst_ready",   {63'd0, req_ready}, 64'd1);
        chk("rst_strobes", {60'd0, lo_we, hi_we, done, err}, 64'd0);
        chk("rst_z",       {result_hi, result_lo}, 64'd0);
        chk("rst_alu",     {alu_a, alu_b}, 64'd0);
        chk("rst_op",      {59'd0, alu_op}, 64'd0);
        clear = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op(OP_ADD, 32'd5, 32'd3, 0, 5'd0, 32'd0, 32'd0);
        chk("add_lo", {32'd0, result_lo}, 64'd8);
        do_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, 5'd0, 32'd0, 32'd0);
        chk("mul_z", {result_hi, result_lo}, 64'h0000_0001_0000_0000);
        do_op(OP_DIV, 32'd7, 32'd2, 0, 5'd0, 32'd0, 32'd0);
        chk("div_z", {result_hi, result_lo}, 64'h0000_0001_0000_0003);
        do_op(OP_DIV, 32'd9, 32'd0, 0, 5'd0, 32'd0, 32'd0);
        do_op(5'b11111, 32'd1, 32'd1, 0, 5'd0, 32'd0, 32'd0);
        do_op(OP_NOT, 32'h0000_FFFF, 32'h1234_5678, 0, 5'd0, 32'd0, 32'd0);
        chk("not_lo", {32'd0, result_lo}, 64'hFFFF_0000);
        do_op(OP_NEG, 32'd1, 32'h5555_5555, 0, 5'd0, 32'd0, 32'd0);
        chk("neg_lo", {32'd0, result_lo}, 64'hFFFF_FFFF);
        do_op(OP_SHRA, 32'hFFFF_FFF5, 32'd2, 1, OP_SUB, 32'd1, 32'd2);
        chk("shra_lo", {32'd0, result_lo}, 64'hFFFF_FFFD);
        do_op(OP_SUB, 32'd1, 32'd2, 0, 5'd0, 32'd0, 32'd0);
        chk("sub_lo", {32'd0, result_lo}, 64'hFFFF_FFFF);

        // Randomized requests, mostly legal, some chained back to back
        for (int i = 0; i < 41; i++) begin
            rop[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 12)];
            rra[i] = $urandom;
            rrb[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (rop[i] == OP_DIV && rra[i] == 32'h8000_0000) rra[i] = 32'h7FFF_FFFF;
            rch[i] = ($urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 40; i++)
            do_op(rop[i], rra[i], rrb[i], rch[i], rop[i+1], rra[i+1], rrb[i+1]);
        do_op(rop[40], rra[40], rrb[40], 0, 5'd0, 32'd0, 32'd0);

        // clear pulsed during MUL EXEC
        req_valid = 1'b1; req_opcode = OP_MUL; req_ra = 32'd3; req_rb = 32'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 clear = 1'b0;
        #1;
        chk("clr_ready",   {63'd0, req_ready}, 64'd1);
        chk("clr_strobes", {60'd0, lo_we, hi_we, done, err}, 64'd0);
        chk("clr_z",       {result_hi, result_lo}, 64'd0);
        chk("clr_alu",     {alu_a, alu_b}, 64'd0);
        chk("clr_op",      {59'd0, alu_op}, 64'd0);
        @(negedge clk);
        clear = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_clr_strobes", {60'd0, lo_we, hi_we, done, err}, 64'd0);
            chk("post_clr_ready",   {63'd0, req_ready}, 64'd1);
        end
        zm = '0;
        do_op(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 0, 5'd0, 32'd0, 32'd0);
        chk("or_lo", {32'd0, result_lo}, 64'hF0F0_0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
